// File: rtl/alu_issue_stage.sv
// RV32I issue stage for OP, OP-IMM, LUI and AUIPC: decodes operands/opcode and presents
// a registered ALU command behind a valid/ready handshake with a one-entry skid buffer.
module alu_issue_stage #(
    parameter int XLEN     = 32,
    parameter int ALU_OP_W = 4
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [31:0]         i_instr,
    input  logic [XLEN-1:0]     i_pc,
    input  logic [XLEN-1:0]     i_rs1_data,
    input  logic [XLEN-1:0]     i_rs2_data,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [XLEN-1:0]     o_op1,
    output logic [XLEN-1:0]     o_op2,
    output logic [ALU_OP_W-1:0] o_alu_op,
    output logic [4:0]          o_rd,
    output logic                o_rd_we,
    output logic                o_illegal
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [ALU_OP_W-1:0] ALU_ADD = ALU_OP_W'(4'b0000);
    localparam logic [ALU_OP_W-1:0] ALU_SRL = ALU_OP_W'(4'b0101);
    localparam logic [ALU_OP_W-1:0] ALU_SUB = ALU_OP_W'(4'b1000);
    localparam logic [ALU_OP_W-1:0] ALU_SRA = ALU_OP_W'(4'b1010);

    typedef struct packed {
        logic [XLEN-1:0]     op1;
        logic [XLEN-1:0]     op2;
        logic [ALU_OP_W-1:0] alu_op;
        logic [4:0]          rd;
        logic                rd_we;
        logic                illegal;
    } cmd_t;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] shamt;
    logic            dec_ill;
    cmd_t            dec_cmd;

    cmd_t out_q, out_d;
    cmd_t skid_q, skid_d;
    logic out_vld_q, out_vld_d;
    logic skid_full_q, skid_full_d;
    logic up_xfer;
    logic out_free;

    assign opcode = i_instr[6:0];
    assign funct3 = i_instr[14:12];
    assign funct7 = i_instr[31:25];
    assign imm_i  = {{(XLEN-12){i_instr[31]}}, i_instr[31:20]};
    assign imm_u  = {{(XLEN-31){i_instr[31]}}, i_instr[30:12], 12'b0};
    assign shamt  = {{(XLEN-5){1'b0}}, i_instr[24:20]};

    // funct3 doubles as the low three alu_op bits for every non-alternate operation
    always_comb begin
        dec_cmd        = '0;
        dec_cmd.alu_op = ALU_ADD;
        dec_cmd.rd     = i_instr[11:7];
        dec_ill        = 1'b0;
        case (opcode)
            OPC_OP: begin
                dec_cmd.op1 = i_rs1_data;
                dec_cmd.op2 = i_rs2_data;
                if (funct7 == F7_BASE) begin
                    dec_cmd.alu_op = ALU_OP_W'({1'b0, funct3});
                end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    dec_cmd.alu_op = ALU_SUB;
                end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                    dec_cmd.alu_op = ALU_SRA;
                end else begin
                    dec_ill = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                dec_cmd.op1    = i_rs1_data;
                dec_cmd.op2    = imm_i;
                dec_cmd.alu_op = ALU_OP_W'({1'b0, funct3});
                if (funct3 == 3'b001) begin
                    dec_cmd.op2 = shamt;
                    dec_ill     = (funct7 != F7_BASE);
                end else if (funct3 == 3'b101) begin
                    dec_cmd.op2 = shamt;
                    if (funct7 == F7_BASE) begin
                        dec_cmd.alu_op = ALU_SRL;
                    end else if (funct7 == F7_ALT) begin
                        dec_cmd.alu_op = ALU_SRA;
                    end else begin
                        dec_ill = 1'b1;
                    end
                end
            end
            OPC_LUI: begin
                dec_cmd.op2 = imm_u;
            end
            OPC_AUIPC: begin
                dec_cmd.op1 = i_pc;
                dec_cmd.op2 = imm_u;
            end
            default: dec_ill = 1'b1;
        endcase
        if (dec_ill) begin
            dec_cmd.op1    = '0;
            dec_cmd.op2    = '0;
            dec_cmd.alu_op = ALU_ADD;
        end
        dec_cmd.illegal = dec_ill;
        dec_cmd.rd_we   = !dec_ill && (i_instr[11:7] != 5'd0);
    end

    assign up_xfer  = i_valid && o_ready;
    assign out_free = !out_vld_q || i_ready;

    // Skid entry drains first; while it is full o_ready is low, so no upstream transfer competes
    always_comb begin
        out_d       = out_q;
        skid_d      = skid_q;
        out_vld_d   = out_vld_q;
        skid_full_d = skid_full_q;
        if (skid_full_q && i_ready) begin
            out_d       = skid_q;
            out_vld_d   = 1'b1;
            skid_full_d = 1'b0;
        end else if (up_xfer && out_free) begin
            out_d     = dec_cmd;
            out_vld_d = 1'b1;
        end else if (up_xfer) begin
            skid_d      = dec_cmd;
            skid_full_d = 1'b1;
        end else if (i_ready) begin
            out_vld_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            out_q       <= '0;
            skid_q      <= '0;
            out_vld_q   <= 1'b0;
            skid_full_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            skid_q      <= skid_d;
            out_vld_q   <= out_vld_d;
            skid_full_q <= skid_full_d;
        end
    end

    assign o_ready   = !skid_full_q;
    assign o_valid   = out_vld_q;
    assign o_op1     = out_q.op1;
    assign o_op2     = out_q.op2;
    assign o_alu_op  = out_q.alu_op;
    assign o_rd      = out_q.rd;
    assign o_rd_we   = out_q.rd_we;
    assign o_illegal = out_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage: expected commands are queued on upstream transfer
// and compared on downstream transfer; covers decode, backpressure and mid-stream reset.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_instr;
    logic [31:0] i_pc;
    logic [31:0] i_rs1_data;
    logic [31:0] i_rs2_data;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_op1;
    logic [31:0] o_op2;
    logic [3:0]  o_alu_op;
    logic [4:0]  o_rd;
    logic        o_rd_we;
    logic        o_illegal;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [3:0]  aop;
        logic [4:0]  rd;
        logic        we;
        logic        ill;
    } exp_t;

    exp_t sbq[$];

    always #5 clk = ~clk;

    alu_issue_stage #(.XLEN(32), .ALU_OP_W(4)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_instr    (i_instr),
        .i_pc       (i_pc),
        .i_rs1_data (i_rs1_data),
        .i_rs2_data (i_rs2_data),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_op1      (o_op1),
        .o_op2      (o_op2),
        .o_alu_op   (o_alu_op),
        .o_rd       (o_rd),
        .o_rd_we    (o_rd_we),
        .o_illegal  (o_illegal)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] op1, input logic [31:0] op2,
                                input logic [3:0] aop, input logic [4:0] rd,
                                input logic we, input logic ill);
        exp_t e;
        e.op1 = op1; e.op2 = op2; e.aop = aop; e.rd = rd; e.we = we; e.ill = ill;
        return e;
    endfunction

    function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
                                           input logic [4:0] rs1, input logic [2:0] f3,
                                           input logic [4:0] rd, input logic [6:0] opc);
        return {f7, rs2, rs1, f3, rd, opc};
    endfunction

    // One clock: drive at negedge, then score the downstream and upstream transfers of this cycle
    task automatic cyc(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic [31:0] r1, input logic [31:0] r2, input logic rdy,
                       input exp_t e);
        exp_t x;
        @(negedge clk);
        i_valid = v; i_instr = ins; i_pc = pc;
        i_rs1_data = r1; i_rs2_data = r2; i_ready = rdy;
        #1;
        if (o_valid && i_ready) begin
            if (sbq.size() == 0) begin
                check_eq("unexpected_out", {31'b0, o_valid}, 32'd0);
            end else begin
                x = sbq.pop_front();
                check_eq("op1",     o_op1,              x.op1);
                check_eq("op2",     o_op2,              x.op2);
                check_eq("alu_op",  {28'b0, o_alu_op},  {28'b0, x.aop});
                check_eq("rd",      {27'b0, o_rd},      {27'b0, x.rd});
                check_eq("rd_we",   {31'b0, o_rd_we},   {31'b0, x.we});
                check_eq("illegal", {31'b0, o_illegal}, {31'b0, x.ill});
            end
        end
        if (v && o_ready) sbq.push_back(e);
    endtask

    task automatic idle(input logic rdy);
        cyc(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, rdy, mk(0, 0, 0, 0, 0, 0));
    endtask

    task automatic check_reset_outs(input string pfx);
        check_eq({pfx, "_valid"},   {31'b0, o_valid},   32'd0);
        check_eq({pfx, "_ready"},   {31'b0, o_ready},   32'd1);
        check_eq({pfx, "_op1"},     o_op1,              32'd0);
        check_eq({pfx, "_op2"},     o_op2,              32'd0);
        check_eq({pfx, "_alu_op"},  {28'b0, o_alu_op},  32'd0);
        check_eq({pfx, "_rd"},      {27'b0, o_rd},      32'd0);
        check_eq({pfx, "_rd_we"},   {31'b0, o_rd_we},   32'd0);
        check_eq({pfx, "_illegal"}, {31'b0, o_illegal}, 32'd0);
    endtask

    initial begin
        logic [31:0] ins_a, ins_b, ins_c;
        rst_n = 1'b0;
        i_valid = 1'b0; i_instr = '0; i_pc = '0;
        i_rs1_data = '0; i_rs2_data = '0; i_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_reset_outs("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Decode coverage at full throughput
        cyc(1, 32'h002081B3, 0, 10, 5, 1, mk(10, 5, 4'b0000, 3, 1, 0));
        cyc(1, 32'h402081B3, 0, 10, 5, 1, mk(10, 5, 4'b1000, 3, 1, 0));
        cyc(1, 32'h40235293, 0, 32'hFFFFFFF0, 0, 1, mk(32'hFFFFFFF0, 2, 4'b1010, 5, 1, 0));
        cyc(1, 32'hFFF00093, 0, 0, 0, 1, mk(0, 32'hFFFFFFFF, 4'b0000, 1, 1, 0));
        cyc(1, 32'h123453B7, 0, 32'h55, 32'h66, 1, mk(0, 32'h12345000, 4'b0000, 7, 1, 0));
        cyc(1, {20'h00001, 5'd4, 7'b0010111}, 32'h100, 0, 0, 1, mk(32'h100, 32'h1000, 4'b0000, 4, 1, 0));
        cyc(1, 32'h00000000, 0, 32'h11, 32'h22, 1, mk(0, 0, 4'b0000, 0, 0, 1));
        cyc(1, 32'h00008033, 0, 7, 9, 1, mk(7, 9, 4'b0000, 0, 0, 0));
        cyc(1, r_type(7'h00, 5'd3, 5'd2, 3'b100, 5'd9, 7'b0110011), 0, 32'hF0, 32'h0F, 1,
            mk(32'hF0, 32'h0F, 4'b0100, 9, 1, 0));
        cyc(1, r_type(7'h00, 5'd3, 5'd2, 3'b111, 5'd10, 7'b0110011), 0, 1, 2, 1,
            mk(1, 2, 4'b0111, 10, 1, 0));
        cyc(1, r_type(7'h20, 5'd3, 5'd2, 3'b001, 5'd11, 7'b0110011), 0, 1, 2, 1,
            mk(0, 0, 4'b0000, 11, 0, 1));
        cyc(1, r_type(7'h01, 5'd0, 5'd1, 3'b001, 5'd1, 7'b0010011), 0, 3, 0, 1,
            mk(0, 0, 4'b0000, 1, 0, 1));
        cyc(1, r_type(7'h00, 5'd31, 5'd1, 3'b101, 5'd12, 7'b0010011), 0, 32'h80000000, 0, 1,
            mk(32'h80000000, 31, 4'b0101, 12, 1, 0));
        cyc(1, {12'h800, 5'd1, 3'b011, 5'd13, 7'b0010011}, 0, 4, 0, 1,
            mk(4, 32'hFFFFF800, 4'b0011, 13, 1, 0));
        cyc(1, r_type(7'h10, 5'd2, 5'd1, 3'b101, 5'd14, 7'b0010011), 0, 4, 0, 1,
            mk(0, 0, 4'b0000, 14, 0, 1));
        idle(1);
        idle(1);

        // Backpressure: A to output, B to skid, C held upstream
        ins_a = r_type(7'h00, 5'd2, 5'd1, 3'b000, 5'd20, 7'b0110011);
        ins_b = r_type(7'h00, 5'd2, 5'd1, 3'b110, 5'd21, 7'b0110011);
        ins_c = r_type(7'h20, 5'd2, 5'd1, 3'b000, 5'd22, 7'b0110011);
        cyc(1, ins_a, 0, 32'hA1, 32'hA2, 0, mk(32'hA1, 32'hA2, 4'b0000, 20, 1, 0));
        cyc(1, ins_b, 0, 32'hB1, 32'hB2, 0, mk(32'hB1, 32'hB2, 4'b0110, 21, 1, 0));
        for (int i = 0; i < 2; i++) begin
            cyc(1, ins_c, 0, 32'hC1, 32'hC2, 0, mk(32'hC1, 32'hC2, 4'b1000, 22, 1, 0));
            check_eq("stall_ready", {31'b0, o_ready}, 32'd0);
            check_eq("stall_valid", {31'b0, o_valid}, 32'd1);
            check_eq("stall_op1",   o_op1,            32'hA1);
            check_eq("stall_rd",    {27'b0, o_rd},    32'd20);
        end
        for (int i = 0; i < 2; i++) begin
            cyc(1, ins_c, 0, 32'hC1, 32'hC2, 1, mk(32'hC1, 32'hC2, 4'b1000, 22, 1, 0));
            check_eq("drain_valid", {31'b0, o_valid}, 32'd1);
        end
        idle(1);
        check_eq("drain_last_valid", {31'b0, o_valid}, 32'd1);
        idle(1);
        check_eq("drain_done", sbq.size(), 32'd0);

        // Reset while output and skid are both occupied
        cyc(1, ins_a, 0, 32'hD1, 32'hD2, 0, mk(32'hD1, 32'hD2, 4'b0000, 20, 1, 0));
        cyc(1, ins_b, 0, 32'hE1, 32'hE2, 0, mk(32'hE1, 32'hE2, 4'b0110, 21, 1, 0));
        cyc(1, ins_c, 0, 32'hF1, 32'hF2, 0, mk(32'hF1, 32'hF2, 4'b1000, 22, 1, 0));
        check_eq("pre_rst_ready", {31'b0, o_ready}, 32'd0);
        #1;
        i_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_outs("midrst");
        sbq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        check_eq("post_rst_ready", {31'b0, o_ready}, 32'd1);
        check_eq("post_rst_valid", {31'b0, o_valid}, 32'd0);
        cyc(1, 32'h002081B3, 0, 32'h77, 32'h88, 1, mk(32'h77, 32'h88, 4'b0000, 3, 1, 0));
        idle(1);
        idle(1);
        idle(1);
        check_eq("final_empty", sbq.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
